// File: rtl/gcd_arbiter_pkg.sv
// gcd_arbiter_pkg: shared definitions for the GCD arbiter.
//   - FSM state encoding (IDLE, ISSUE, WAIT, DELIVER)
//   - default values for the N, W and TMO parameters
package gcd_arbiter_pkg;

    localparam int unsigned N_DEF   = 4;
    localparam int unsigned W_DEF   = 16;
    localparam int unsigned TMO_DEF = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        WAIT    = 2'b10,
        DELIVER = 2'b11
    } state_t;

endpackage

// File: rtl/gcd_arbiter_rr_grant.sv
// rr_grant: combinational round-robin grant.
// The search starts at index ptr+1 (mod N) and returns the first requester found.
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  index of the most recently served requester
//   grant out N   one-hot grant (all zero when no request)
//   idx   out IW  index of the granted requester
//   any   out 1   at least one request is pending
module rr_grant
    import gcd_arbiter_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk the requesters in priority order ptr+1, ptr+2, ... and keep the first hit.
    always_comb begin
        int unsigned cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any && req[IW'(cand)]) begin
                any               = 1'b1;
                idx               = IW'(cand);
                grant[IW'(cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one GCD engine among N requesters with round-robin arbitration.
// A zero operand bypasses the engine; a watchdog aborts engine jobs after TMO cycles.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   req[N]                per-requester request, held until its rsp_valid bit
//   a_in, b_in [N*W]      packed operands, slice i belongs to requester i
//   rsp_valid[N]          one-hot, one-cycle result pulse
//   rsp_data[W], rsp_err  result and watchdog-abort flag, held between pulses
//   eng_start             one-cycle engine start pulse
//   eng_a, eng_b [W]      engine operands, stable from eng_start until eng_done
//   eng_done, eng_result  engine completion (level or pulse) and result
//   busy                  high whenever the FSM is not in IDLE
module gcd_arbiter
    import gcd_arbiter_pkg::*;
#(
    parameter int unsigned N   = N_DEF,
    parameter int unsigned W   = W_DEF,
    parameter int unsigned TMO = TMO_DEF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] a_in,
    input  logic [N*W-1:0] b_in,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_err,
    output logic           eng_start,
    output logic [W-1:0]   eng_a,
    output logic [W-1:0]   eng_b,
    input  logic           eng_done,
    input  logic [W-1:0]   eng_result,
    output logic           busy
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = (TMO > 0) ? $clog2(TMO + 1) : 1;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   grant_idx;
    logic [N-1:0]    grant_oh;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [W-1:0]    result;
    logic            err;
    logic [CW-1:0]   wd_cnt;

    logic [N-1:0]    rr_oh;
    logic [IW-1:0]   rr_idx;
    logic            rr_any;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;

    // Round-robin arbiter over the live request vector.
    rr_grant #(
        .N  (N),
        .IW (IW)
    ) u_rr_grant (
        .req   (req),
        .ptr   (ptr),
        .grant (rr_oh),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    // Operand slices of the requester that would be granted this cycle.
    assign sel_a = a_in[32'(rr_idx) * W +: W];
    assign sel_b = b_in[32'(rr_idx) * W +: W];

    // Arbitration / engine-control FSM with registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= IW'(N - 1);
            grant_idx <= '0;
            grant_oh  <= '0;
            op_a      <= '0;
            op_b      <= '0;
            result    <= '0;
            err       <= 1'b0;
            wd_cnt    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            eng_start <= 1'b0;
            eng_a     <= '0;
            eng_b     <= '0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= '0;
            eng_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (rr_any) begin
                        grant_idx <= rr_idx;
                        grant_oh  <= rr_oh;
                        op_a      <= sel_a;
                        op_b      <= sel_b;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if ((op_a == '0) || (op_b == '0)) begin
                        // gcd(x,0) = x and gcd(0,0) = 0, so OR gives the answer.
                        result <= op_a | op_b;
                        err    <= 1'b0;
                        state  <= DELIVER;
                    end else begin
                        eng_a     <= op_a;
                        eng_b     <= op_b;
                        eng_start <= 1'b1;
                        wd_cnt    <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // eng_done is tested first so it wins a tie with the watchdog.
                    if (eng_done) begin
                        result <= eng_result;
                        err    <= 1'b0;
                        state  <= DELIVER;
                    end else if (wd_cnt >= CW'(TMO)) begin
                        result <= '0;
                        err    <= 1'b1;
                        state  <= DELIVER;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                DELIVER: begin
                    rsp_valid <= grant_oh;
                    rsp_data  <= result;
                    rsp_err   <= err;
                    ptr       <= grant_idx;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: self-checking bench for gcd_arbiter with a behavioural GCD engine,
// a table of single-request vectors, hand-written corner sequences and random rounds.
module tb_gcd_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 16;
    localparam int unsigned TMO = 255;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           eng_start;
    logic [W-1:0]   eng_a;
    logic [W-1:0]   eng_b;
    logic           eng_done;
    logic [W-1:0]   eng_result;
    logic           busy;

    int checks    = 0;
    int failures  = 0;
    int starts    = 0;
    int eng_lat   = 0;   // cycles from eng_start rising to eng_done rising; 0 = never
    int rem       = 0;
    int ptr_model = N - 1;

    gcd_arbiter #(
        .N   (N),
        .W   (W),
        .TMO (TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    function automatic int unsigned ref_gcd(input int unsigned x, input int unsigned y);
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int next_rr(input logic [N-1:0] pend, input int last);
        for (int k = 1; k <= N; k++) begin
            if (pend[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Behavioural engine: one-cycle eng_done pulse eng_lat cycles after eng_start.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            rem        <= 0;
            eng_done   <= 1'b0;
            eng_result <= '0;
        end else begin
            eng_done <= 1'b0;
            if (eng_start) begin
                if (eng_lat == 1) begin
                    eng_done   <= 1'b1;
                    eng_result <= W'(ref_gcd(eng_a, eng_b));
                end else begin
                    rem <= (eng_lat > 1) ? eng_lat - 1 : 0;
                end
            end else if (rem > 0) begin
                rem <= rem - 1;
                if (rem == 1) begin
                    eng_done   <= 1'b1;
                    eng_result <= W'(ref_gcd(eng_a, eng_b));
                end
            end
        end
    end

    always @(posedge clock) begin
        if (eng_start) starts <= starts + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_rsp(input int bound, output bit got, output int cyc);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < bound) begin
            tick();
            cyc++;
            if (rsp_valid != '0) got = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"},  rsp_data,  0);
        check({tag, "_rsp_err"},   rsp_err,   0);
        check({tag, "_eng_start"}, eng_start, 0);
        check({tag, "_eng_a"},     eng_a,     0);
        check({tag, "_eng_b"},     eng_b,     0);
        check({tag, "_busy"},      busy,      0);
    endtask

    // Single request on requester idx; called at #1 after a clock edge with the FSM idle.
    task automatic run_job(input string tag, input int idx, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int lat, input logic [W-1:0] exp_data,
                           input logic exp_err, input int exp_latency, input int exp_starts);
        int s0;
        int cyc;
        bit got;
        eng_lat          = lat;
        a_in[idx*W +: W] = a;
        b_in[idx*W +: W] = b;
        s0               = starts;
        req              = onehot(idx);
        wait_rsp(1000, got, cyc);
        req = '0;
        check({tag, "_seen"},    got,          1);
        check({tag, "_valid"},   rsp_valid,    onehot(idx));
        check({tag, "_data"},    rsp_data,     exp_data);
        check({tag, "_err"},     rsp_err,      exp_err);
        check({tag, "_latency"}, cyc,          exp_latency);
        check({tag, "_starts"},  starts - s0,  exp_starts);
        check({tag, "_idle"},    busy,         0);
        tick();
        check({tag, "_pulse1"},  rsp_valid,    0);
        check({tag, "_hold"},    rsp_data,     exp_data);
        ptr_model = idx;
    endtask

    typedef struct {
        string      tag;
        int         idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int         lat;
        logic [W-1:0] exp_data;
        logic       exp_err;
        int         exp_latency;
        int         exp_starts;
    } vec_t;

    vec_t vecs[10];

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        bit got;
        int pulses;
        int order[5];

        reset = 1'b1;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Fairness: all four requests held; grants 0,1,2,3,0 starting from reset ptr.
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            a_in[i*W +: W] = W'(6 * (i + 2));
            b_in[i*W +: W] = W'(4 * (i + 2));
        end
        eng_lat = 2;
        req     = '1;
        for (int n = 0; n < 5; n++) begin
            wait_rsp(100, got, cyc);
            check("fair_seen",  got,       1);
            check("fair_grant", rsp_valid, onehot(order[n]));
            check("fair_data",  rsp_data,  2 * (order[n] + 2));
            ptr_model = order[n];
        end
        req = '0;
        tick();

        vecs[0] = '{"basic",      0, 16'd48,    16'd18,  5,   16'd6,   1'b0, 9,   1};
        vecs[1] = '{"bypass_b",   1, 16'd0,     16'd21,  5,   16'd21,  1'b0, 3,   0};
        vecs[2] = '{"bypass_00",  2, 16'd0,     16'd0,   5,   16'd0,   1'b0, 3,   0};
        vecs[3] = '{"bypass_a",   3, 16'd7,     16'd0,   5,   16'd7,   1'b0, 3,   0};
        vecs[4] = '{"lat1",       0, 16'd17,    16'd5,   1,   16'd1,   1'b0, 5,   1};
        vecs[5] = '{"wide",       1, 16'd65535, 16'd255, 3,   16'd255, 1'b0, 7,   1};
        vecs[6] = '{"pow2",       2, 16'd1024,  16'd768, 2,   16'd256, 1'b0, 6,   1};
        vecs[7] = '{"tie",        3, 16'd100,   16'd75,  255, 16'd25,  1'b0, 259, 1};
        vecs[8] = '{"late",       0, 16'd36,    16'd24,  256, 16'd0,   1'b1, 259, 1};
        vecs[9] = '{"never",      1, 16'd12,    16'd18,  0,   16'd0,   1'b1, 259, 1};
        for (int v = 0; v < 10; v++) begin
            run_job(vecs[v].tag, vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].lat,
                    vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_latency, vecs[v].exp_starts);
            tick();
        end

        // Requester drops req two cycles into its job and must still get its pulse.
        eng_lat        = 5;
        a_in[2*W +: W] = 16'd48;
        b_in[2*W +: W] = 16'd18;
        req            = 4'b0100;
        tick();
        tick();
        req = '0;
        wait_rsp(50, got, cyc);
        check("drop_seen",    got,       1);
        check("drop_valid",   rsp_valid, 4'b0100);
        check("drop_data",    rsp_data,  6);
        check("drop_latency", cyc + 2,   9);
        ptr_model = 2;
        tick();

        // Reset while waiting on a dead engine: job abandoned, no pulse.
        eng_lat        = 0;
        a_in[0*W +: W] = 16'd30;
        b_in[0*W +: W] = 16'd12;
        req            = 4'b0001;
        for (int i = 0; i < 10; i++) tick();
        check("wait_busy",  busy,  1);
        check("wait_eng_a", eng_a, 30);
        check("wait_eng_b", eng_b, 12);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        req    = '0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid != '0) pulses++;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid != '0) pulses++;
        end
        check("midrst_no_pulse", pulses, 0);
        ptr_model = N - 1;
        run_job("post_rst", 2, 16'd48, 16'd18, 5, 16'd6, 1'b0, 9, 1);
        tick();

        // Random rounds: several requests pending at once, order from the RR model.
        for (int r = 0; r < 20; r++) begin
            logic [N-1:0] pend;
            int lat;
            pend    = N'($urandom_range(1, (1 << N) - 1));
            lat     = $urandom_range(1, 6);
            eng_lat = lat;
            for (int i = 0; i < N; i++) begin
                int unsigned g;
                g = $urandom_range(1, 50);
                a_in[i*W +: W] = W'(g * $urandom_range(0, 40));
                b_in[i*W +: W] = W'(g * $urandom_range(0, 40));
            end
            req = pend;
            while (pend != '0) begin
                int e_idx;
                int exp_lat;
                logic [W-1:0] ea;
                logic [W-1:0] eb;
                e_idx   = next_rr(pend, ptr_model);
                ea      = a_in[e_idx*W +: W];
                eb      = b_in[e_idx*W +: W];
                exp_lat = (ea == '0 || eb == '0) ? 3 : 4 + lat;
                wait_rsp(400, got, cyc);
                check("rnd_seen", got, 1);
                if (!got) break;
                check("rnd_grant",   rsp_valid, onehot(e_idx));
                check("rnd_data",    rsp_data,  ref_gcd(ea, eb));
                check("rnd_err",     rsp_err,   0);
                check("rnd_latency", cyc,       exp_lat);
                pend[e_idx] = 1'b0;
                req[e_idx]  = 1'b0;
                ptr_model   = e_idx;
            end
            req = '0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
